wb_scoreboard: RTL and testbench
================================

// Module: wb_scoreboard
// PURPOSE
//  Writeback arbiter plus register scoreboard sitting directly upstream of the register file.
//  Merges ALU results and (higher priority) load returns into the single reg file write port
//  (dest/reg_write/write_data), and tracks pending destinations so decode stalls on RAW/WAW hazards.
//  The reg file writes at posedge and reads combinationally (old value in the write cycle), so a
//  pending bit holds until the write has actually committed.
// PARAMETERS
//  MAX_LOADS   2   max outstanding loads (issued, not yet returned); 1..7
// PORTS
//  clk          in   1   clock
//  rst          in   1   asynchronous active-high reset
//  iss_valid    in   1   decode presents an instruction
//  iss_rd       in   5   its destination (0 = no write)
//  iss_is_load  in   1   instruction is a load
//  iss_src1     in   5   source 1 index
//  iss_src2     in   5   source 2 index
//  iss_stall    out  1   decode must hold; instruction not issued this cycle
//  alu_valid    in   1   ALU result available
//  alu_rd       in   5   ALU result destination
//  alu_data     in   32  ALU result
//  alu_ready    out  1   ALU result accepted this cycle when alu_valid=1
//  ld_valid     in   1   load data return (cannot be back-pressured)
//  ld_rd        in   5   load destination
//  ld_data      in   32  load data
//  dest         out  5   reg file write index
//  reg_write    out  1   reg file write enable
//  write_data   out  32  reg file write data
//  err          out  1   sticky protocol error
// BEHAVIOUR
//  - Reset (async, immediate): pending[31:0]=0, ld_cnt=0, dest=0, reg_write=0, write_data=0, err=0.
//    Reset mid-operation discards in-flight state; returns arriving after reset set err.
//  - pending[0] is hardwired 0; x0 never causes a hazard and is never written.
//  - iss_stall (comb.) = iss_valid & ( (iss_src1!=0 & pending[iss_src1]) | (iss_src2!=0 &
//    pending[iss_src2]) | (iss_rd!=0 & pending[iss_rd]) | (iss_is_load & ld_cnt==MAX_LOADS) ).
//  - Issue fires when iss_valid & !iss_stall: at posedge set pending[iss_rd] if iss_rd!=0;
//    ld_cnt+1 if iss_is_load.
//  - Arbitration: load wins. alu_ready = !ld_valid (comb.). Accepted source = ld if ld_valid,
//    else ALU if alu_valid. Accepted result registered into dest/write_data; reg_write=1 next
//    cycle iff accepted rd!=0 (1-cycle latency). No acceptance -> reg_write=0, dest/data hold.
//  - ld_cnt-1 on every ld_valid cycle. Simultaneous load issue and return: count unchanged.
//  - Commit: on the posedge where reg_write=1, pending[dest] clears. Hence a register is
//    readable by decode the cycle after commit; decode stalls through accept and commit cycles.
//  - Set and clear on the same edge always target different registers (WAW stall guarantees).
//  - err set (sticky until rst) if accepted result rd has pending[rd]=0, or ld_valid with
//    ld_cnt==0. Erroneous result is still written if rd!=0; ld_cnt saturates at 0.
//  - Back-to-back accepts each produce one write per cycle; throughput 1 result/cycle.
// TESTING
//  1 Reset: assert rst mid-burst -> all outputs 0 at once, pending clear, iss_stall=0 after release.
//  2 RAW: issue add x5 (alu), next cycle issue with src1=5 -> stall; alu_valid rd=5 data=0x1234 ->
//    reg_write=1 dest=5 data=0x1234 one cycle later; stall drops the cycle after commit.
//  3 Conflict: ld_valid rd=3 data=0xAAAA and alu_valid rd=4 same cycle -> alu_ready=0, x3 written
//    first; ALU held, x4=0x... written next cycle.
//  4 Load limit (MAX_LOADS=2): issue loads to x1,x2, third load -> stall; one return -> third issues.
//  5 x0: issue rd=0 then src1=0 -> never stalls; result to rd=0 -> reg_write stays 0, err stays 0.
//  6 Protocol: ld_valid with no load outstanding -> err=1 and remains 1 until rst.

Source files
------------

// File: rtl/wb_scoreboard_if.sv
// Decode/ALU/load-return/reg-file signal bundle for wb_scoreboard.
// The scoreboard is the slave; decode, ALU and memory together form the master.
interface wb_scoreboard_if;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_is_load;
    logic [4:0]  iss_src1;
    logic [4:0]  iss_src2;
    logic        iss_stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  dest;
    logic        reg_write;
    logic [31:0] write_data;
    logic        err;

    modport master (
        output iss_valid, iss_rd, iss_is_load, iss_src1, iss_src2,
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        input  iss_stall, alu_ready, dest, reg_write, write_data, err
    );

    modport slave (
        input  iss_valid, iss_rd, iss_is_load, iss_src1, iss_src2,
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        output iss_stall, alu_ready, dest, reg_write, write_data, err
    );
endinterface

// File: rtl/wb_scoreboard.sv
// Writeback arbiter (load beats ALU) driving the single reg-file write port, plus a
// pending-destination scoreboard that stalls decode on RAW/WAW hazards and load overflow.
module wb_scoreboard #(
    parameter int unsigned MAX_LOADS = 2
) (
    input logic          clk,
    input logic          rst,
    wb_scoreboard_if.slave bus
);
    logic [31:0] pending_q, pending_d;
    logic [2:0]  ld_cnt_q, ld_cnt_d;
    logic [4:0]  dest_q, dest_d;
    logic        reg_write_q, reg_write_d;
    logic [31:0] write_data_q, write_data_d;
    logic        err_q, err_d;

    logic        ld_full, ld_empty, issue_fire, issue_load, ld_ret;
    logic        acc_valid;
    logic [4:0]  acc_rd;
    logic [31:0] acc_data;

    assign ld_full  = (ld_cnt_q == 3'(MAX_LOADS));
    assign ld_empty = (ld_cnt_q == 3'd0);

    assign bus.iss_stall = bus.iss_valid &
        ((bus.iss_src1 != 5'd0 & pending_q[bus.iss_src1]) |
         (bus.iss_src2 != 5'd0 & pending_q[bus.iss_src2]) |
         (bus.iss_rd   != 5'd0 & pending_q[bus.iss_rd])   |
         (bus.iss_is_load & ld_full));

    assign issue_fire = bus.iss_valid & ~bus.iss_stall;
    assign issue_load = issue_fire & bus.iss_is_load;
    assign ld_ret     = bus.ld_valid & ~ld_empty;

    assign bus.alu_ready = ~bus.ld_valid;
    assign acc_valid     = bus.ld_valid | bus.alu_valid;
    assign acc_rd        = bus.ld_valid ? bus.ld_rd   : bus.alu_rd;
    assign acc_data      = bus.ld_valid ? bus.ld_data : bus.alu_data;

    always_comb begin
        // Commit clears before issue sets; the WAW stall keeps them on different registers.
        pending_d = pending_q;
        if (reg_write_q) pending_d[dest_q] = 1'b0;
        if (issue_fire && bus.iss_rd != 5'd0) pending_d[bus.iss_rd] = 1'b1;
        pending_d[0] = 1'b0;

        ld_cnt_d = ld_cnt_q;
        unique case ({issue_load, ld_ret})
            2'b10:   ld_cnt_d = ld_cnt_q + 3'd1;
            2'b01:   ld_cnt_d = ld_cnt_q - 3'd1;
            default: ld_cnt_d = ld_cnt_q;
        endcase

        dest_d       = dest_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        if (acc_valid) begin
            dest_d       = acc_rd;
            write_data_d = acc_data;
            reg_write_d  = (acc_rd != 5'd0);
        end

        err_d = err_q |
                (acc_valid & acc_rd != 5'd0 & ~pending_q[acc_rd]) |
                (bus.ld_valid & ld_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            ld_cnt_q     <= '0;
            dest_q       <= '0;
            reg_write_q  <= 1'b0;
            write_data_q <= '0;
            err_q        <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            ld_cnt_q     <= ld_cnt_d;
            dest_q       <= dest_d;
            reg_write_q  <= reg_write_d;
            write_data_q <= write_data_d;
            err_q        <= err_d;
        end
    end

    assign bus.dest       = dest_q;
    assign bus.reg_write  = reg_write_q;
    assign bus.write_data = write_data_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_wb_scoreboard.sv
// Randomized bench for wb_scoreboard: a timeline model (cycle at which each register becomes
// readable, queues of outstanding producers) predicts stalls, writes and the error flag.
module tb_wb_scoreboard;
    localparam int unsigned MAXL = 2;
    localparam int          INF  = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_scoreboard_if bus ();

    wb_scoreboard #(.MAX_LOADS(MAXL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int ready_at [32];
    logic [4:0] ldq  [$];
    logic [4:0] aluq [$];
    logic [4:0]  e_dest;
    logic        e_we;
    logic [31:0] e_data;
    logic        e_err;
    bit          fired_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // A register is busy from its issue until the cycle after its write commits.
    function automatic bit busy(input logic [4:0] r);
        return (r != 5'd0) && (cyc < ready_at[r]);
    endfunction

    task automatic idle();
        bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.iss_is_load = 1'b0;
        bus.iss_src1 = '0; bus.iss_src2 = '0;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
    endtask

    task automatic model_reset();
        foreach (ready_at[i]) ready_at[i] = 0;
        ldq.delete();
        aluq.delete();
        e_dest = '0; e_we = 1'b0; e_data = '0; e_err = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2,
                         input bit ld);
        bus.iss_valid = 1'b1; bus.iss_rd = rd; bus.iss_src1 = s1; bus.iss_src2 = s2;
        bus.iss_is_load = ld;
    endtask

    // Called at posedge+1; checks combinational outputs, advances one clock, checks registered ones.
    task automatic tick();
        bit exp_stall, acc;
        logic [4:0]  i_rd, a_rd;
        logic [31:0] a_data;
        bit i_ld, l_v;
        #1;
        exp_stall = bus.iss_valid && (busy(bus.iss_src1) || busy(bus.iss_src2) ||
                    busy(bus.iss_rd) || (bus.iss_is_load && ldq.size() == MAXL));
        chk("iss_stall", bus.iss_stall, exp_stall);
        chk("alu_ready", bus.alu_ready, !bus.ld_valid);
        fired_g = bus.iss_valid && !exp_stall;
        i_rd = bus.iss_rd; i_ld = bus.iss_is_load; l_v = bus.ld_valid;
        acc = bus.ld_valid || bus.alu_valid;
        a_rd   = bus.ld_valid ? bus.ld_rd : bus.alu_rd;
        a_data = bus.ld_valid ? bus.ld_data : bus.alu_data;
        @(posedge clk);
        #1;
        if (l_v) begin
            if (ldq.size() == 0) e_err = 1'b1;
            else void'(ldq.pop_front());
        end else if (acc && aluq.size() != 0) begin
            void'(aluq.pop_front());
        end
        if (acc) begin
            if (a_rd != 5'd0 && !(cyc < ready_at[a_rd])) e_err = 1'b1;
            else if (a_rd != 5'd0) ready_at[a_rd] = cyc + 2;
            e_dest = a_rd; e_data = a_data; e_we = (a_rd != 5'd0);
        end else begin
            e_we = 1'b0;
        end
        if (fired_g) begin
            if (i_rd != 5'd0) ready_at[i_rd] = INF;
            if (i_ld) ldq.push_back(i_rd);
            else      aluq.push_back(i_rd);
        end
        cyc++;
        chk("reg_write", bus.reg_write, e_we);
        chk("dest", bus.dest, e_dest);
        chk("write_data", bus.write_data, e_data);
        chk("err", bus.err, e_err);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_reg_write", bus.reg_write, 1'b0);
        chk("rst_dest", bus.dest, 5'd0);
        chk("rst_write_data", bus.write_data, 32'd0);
        chk("rst_err", bus.err, 1'b0);
        idle();
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        issue(5'd5, 5'd5, 5'd3, 1'b1);
        #1 chk("rst_stall", bus.iss_stall, 1'b0);
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        #12;
        chk("init_reg_write", bus.reg_write, 1'b0);
        chk("init_err", bus.err, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // RAW on x5
        issue(5'd5, 5'd0, 5'd0, 1'b0); tick();
        issue(5'd6, 5'd5, 5'd0, 1'b0); tick();
        chk("raw_stall_held", bus.iss_stall, 1'b1);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234; tick();
        chk("raw_data", bus.write_data, 32'h1234);
        bus.alu_valid = 1'b0; tick();
        tick();
        chk("raw_issued", fired_g, 1'b1);

        // load/ALU same-cycle conflict
        do_reset();
        issue(5'd3, 5'd0, 5'd0, 1'b1); tick();
        issue(5'd4, 5'd0, 5'd0, 1'b0); tick();
        idle();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_data = 32'hAAAA;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h5555; tick();
        chk("conf_first", bus.dest, 5'd3);
        bus.ld_valid = 1'b0; tick();
        chk("conf_second", bus.write_data, 32'h5555);
        bus.alu_valid = 1'b0; tick();

        // outstanding-load limit
        do_reset();
        issue(5'd1, 5'd0, 5'd0, 1'b1); tick();
        issue(5'd2, 5'd0, 5'd0, 1'b1); tick();
        issue(5'd7, 5'd0, 5'd0, 1'b1); tick();
        chk("ldlim_stall", fired_g, 1'b0);
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd1; bus.ld_data = 32'h11; tick();
        bus.ld_valid = 1'b0; tick();
        chk("ldlim_issue", fired_g, 1'b1);
        idle(); tick();

        // x0 never hazards, never written
        do_reset();
        issue(5'd0, 5'd0, 5'd0, 1'b0); tick();
        issue(5'd0, 5'd0, 5'd0, 1'b0); tick();
        chk("x0_nostall", fired_g, 1'b1);
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hDEAD; tick();
        chk("x0_nowrite", bus.reg_write, 1'b0);
        bus.alu_valid = 1'b0; tick();

        // spurious load return -> sticky err
        do_reset();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'h99; tick();
        bus.ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("err_sticky", bus.err, 1'b1);
        do_reset();

        // randomized traffic with a reset in the middle
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            if (!bus.iss_valid || fired_g) begin
                bus.iss_valid   = ($urandom_range(0, 3) != 0);
                bus.iss_rd      = 5'($urandom_range(0, 7));
                bus.iss_src1    = 5'($urandom_range(0, 7));
                bus.iss_src2    = 5'($urandom_range(0, 7));
                bus.iss_is_load = ($urandom_range(0, 2) == 0);
            end
            bus.ld_valid = (ldq.size() != 0) && ($urandom_range(0, 2) == 0);
            bus.ld_rd    = (ldq.size() != 0) ? ldq[0] : 5'd0;
            bus.ld_data  = $urandom;
            bus.alu_valid = (aluq.size() != 0) && ($urandom_range(0, 1) == 0);
            bus.alu_rd    = (aluq.size() != 0) ? aluq[0] : 5'd0;
            bus.alu_data  = $urandom;
            fired_g = 1'b0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
